// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures retiring register writes (rd, data) into a
// first-word-fall-through FIFO drained over a valid/ready port; overflow drops and counts.
module wb_trace_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_valid_i,
    input  logic [4:0]                wb_rd_i,
    input  logic [DATA_W-1:0]         wb_data_i,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output logic [4:0]                trace_rd_o,
    output logic [DATA_W-1:0]         trace_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o,
    output logic [CNT_W-1:0]          drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]        r_mem_rd   [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic w_push_req;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // x0 writes never reach the FIFO and never count as drops.
    assign w_push_req = wb_valid_i && (wb_rd_i != 5'd0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = trace_valid_o && trace_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = rst && w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {CNT_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Storage is deliberately left uncleared by reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= wb_rd_i;
            r_mem_data[r_wr_ptr] <= wb_data_i;
        end
    end

    assign trace_valid_o = (r_count != '0);
    assign trace_rd_o    = trace_valid_o ? r_mem_rd[r_rd_ptr]   : 5'd0;
    assign trace_data_o  = trace_valid_o ? r_mem_data[r_rd_ptr] : '0;
    assign count_o       = r_count;
    assign overflow_o    = r_overflow;
    assign drop_cnt_o    = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_wb_trace_buffer;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;
    localparam int SAT    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid_i;
    logic [4:0]        wb_rd_i;
    logic [DATA_W-1:0] wb_data_i;
    logic              trace_valid_o;
    logic              trace_ready_i;
    logic [4:0]        trace_rd_o;
    logic [DATA_W-1:0] trace_data_o;
    logic [3:0]        count_o;
    logic              overflow_o;
    logic [CNT_W-1:0]  drop_cnt_o;

    wb_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_rd_o(trace_rd_o), .trace_data_o(trace_data_o),
        .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   armed  = 1'b0;

    ent_t mq[$];
    bit   m_ovf;
    int   m_drops;
    ent_t got[$];
    ent_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated from the inputs at each rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            bit pop;
            bit push;
            pop  = (mq.size() != 0) && trace_ready_i;
            push = wb_valid_i && (wb_rd_i != 5'd0);
            if (push && mq.size() == DEPTH && !pop) begin
                m_ovf = 1'b1;
                if (m_drops < SAT) m_drops++;
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back('{rd: wb_rd_i, data: wb_data_i});
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_valid", 64'(trace_valid_o), 64'(mq.size() != 0));
            chk("m_count", 64'(count_o), 64'(mq.size()));
            chk("m_rd",    64'(trace_rd_o),   64'(mq.size() != 0 ? mq[0].rd   : 5'd0));
            chk("m_data",  64'(trace_data_o), 64'(mq.size() != 0 ? mq[0].data : 32'd0));
            chk("m_ovf",   64'(overflow_o), 64'(m_ovf));
            chk("m_drops", 64'(drop_cnt_o), 64'(m_drops));
        end
    end

    task automatic cyc(input logic v, input logic [4:0] rd, input logic [DATA_W-1:0] d,
                       input logic rdy, input logic r = 1'b1);
        wb_valid_i    = v;
        wb_rd_i       = rd;
        wb_data_i     = d;
        trace_ready_i = rdy;
        rst           = r;
        if (r && rdy && trace_valid_o) got.push_back('{rd: trace_rd_o, data: trace_data_o});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_got(input string name);
        chk({name, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(name, 64'(got[i]), 64'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; trace_ready_i = 1'b0;

        // Reset held two cycles with a write offered.
        cyc(1'b1, 5'd3, 32'hAB, 1'b0, 1'b0);
        armed = 1'b1;
        cyc(1'b1, 5'd3, 32'hAB, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(trace_valid_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("rst_head", 64'({trace_rd_o, trace_data_o}), 64'd0);

        // Ordering, with a stalled head.
        cyc(1'b1, 5'd1, 32'h11, 1'b0);
        chk("lat_valid", 64'(trace_valid_o), 64'd1);
        cyc(1'b1, 5'd2, 32'h22, 1'b0);
        cyc(1'b1, 5'd3, 32'h33, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        chk("ord_count", 64'(count_o), 64'd3);
        chk("ord_head", 64'({trace_rd_o, trace_data_o}), {27'd0, 5'd1, 32'h11});
        for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 32'h0, 1'b1);
        chk("ord_empty", 64'(trace_valid_o), 64'd0);
        exp_q = '{'{5'd1, 32'h11}, '{5'd2, 32'h22}, '{5'd3, 32'h33}};
        chk_got("ord_out");

        // x0 filter.
        cyc(1'b1, 5'd0, 32'hDEADBEEF, 1'b0);
        chk("x0_count", 64'(count_o), 64'd0);
        cyc(1'b1, 5'd5, 32'h55, 1'b0);
        chk("x0_count1", 64'(count_o), 64'd1);
        cyc(1'b0, 5'd0, 32'h0, 1'b1);
        cyc(1'b0, 5'd0, 32'h0, 1'b1);
        chk("x0_drop", 64'(drop_cnt_o), 64'd0);
        exp_q = '{'{5'd5, 32'h55}};
        chk_got("x0_out");

        // Overflow and drop-counter saturation.
        for (int i = 1; i <= 10; i++) cyc(1'b1, 5'(i), 32'(i), 1'b0);
        chk("ovf_count", 64'(count_o), 64'd8);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        chk("ovf_drop", 64'(drop_cnt_o), 64'd2);
        for (int i = 0; i < 8; i++) cyc(1'b1, 5'd20, 32'hEE, 1'b0);
        chk("ovf_sat", 64'(drop_cnt_o), 64'(SAT));
        for (int i = 0; i < 9; i++) cyc(1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 1; i <= 8; i++) exp_q.push_back('{5'(i), 32'(i)});
        chk_got("ovf_out");
        chk("ovf_sticky", 64'(overflow_o), 64'd1);

        // Full with simultaneous push/pop, then continuous streaming through wrap.
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0);
            exp_q.push_back('{5'(i), 32'h100 + 32'(i)});
        end
        cyc(1'b1, 5'd9, 32'h99, 1'b1);
        exp_q.push_back('{5'd9, 32'h99});
        chk("full_count", 64'(count_o), 64'd8);
        chk("full_drop", 64'(drop_cnt_o), 64'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 5'((i % 31) + 1), 32'h1000 + 32'(i), 1'b1);
            exp_q.push_back('{5'((i % 31) + 1), 32'h1000 + 32'(i)});
        end
        chk("strm_count", 64'(count_o), 64'd8);
        for (int i = 0; i < 9; i++) cyc(1'b0, 5'd0, 32'h0, 1'b1);
        chk_got("full_out");

        // Reset mid-operation with a push on the reset cycle.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 5'(i + 10), 32'h40 + 32'(i), 1'b0);
        cyc(1'b1, 5'd15, 32'hBAD, 1'b0, 1'b0);
        chk("mrst_count", 64'(count_o), 64'd0);
        chk("mrst_valid", 64'(trace_valid_o), 64'd0);
        cyc(1'b1, 5'd7, 32'h77, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1);
        cyc(1'b0, 5'd0, 32'h0, 1'b1);
        exp_q = '{'{5'd7, 32'h77}};
        chk_got("mrst_out");

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
